// File: rtl/l1_pkg.sv
// Shared types and constants for the Level-1 logic slice.
package l1_pkg;

  localparam int unsigned DEC_W = 4;

  // Comparator result flags, ordered {gt, lt, eq}.
  typedef logic [2:0] cmp_flags_t;

endpackage

// File: rtl/l1_and2.sv
// Two-input AND primitive (combinational).
module l1_and2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/l1_cmp.sv
// Unsigned magnitude comparator producing {gt, lt, eq} flags.
module l1_cmp
  import l1_pkg::*;
#(
  parameter int unsigned CMP_W = 4
) (
  input  logic [CMP_W-1:0] x,
  input  logic [CMP_W-1:0] y,
  output cmp_flags_t       flags
);

  assign flags = {(x > y), (x < y), (x == y)};

endmodule

// File: rtl/l1_dec2to4.sv
// 2-to-4 one-hot decoder; a is the select MSB, b the LSB.
module l1_dec2to4
  import l1_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [DEC_W-1:0] dec
);

  always_comb begin
    dec          = '0;
    dec[{a, b}]  = 1'b1;
  end

endmodule

// File: rtl/l1_logic_slice.sv
// Registered Level-1 logic slice: AND, 2-to-4 decode and unsigned compare
// with one cycle of latency and a valid qualifier.
module l1_logic_slice
  import l1_pkg::*;
#(
  parameter int unsigned CMP_W = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic [CMP_W-1:0] x,
  input  logic [CMP_W-1:0] y,
  output logic             out_valid,
  output logic             and_q,
  output logic [DEC_W-1:0] dec_q,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  logic             and_d;
  logic [DEC_W-1:0] dec_d;
  cmp_flags_t       flags_d;
  cmp_flags_t       flags_q;

  l1_and2 u_and2 (
    .a (a),
    .b (b),
    .y (and_d)
  );

  l1_dec2to4 u_dec (
    .a   (a),
    .b   (b),
    .dec (dec_d)
  );

  l1_cmp #(
    .CMP_W (CMP_W)
  ) u_cmp (
    .x     (x),
    .y     (y),
    .flags (flags_d)
  );

  // Data registers only load on a valid sample; otherwise they hold.
  always_ff @(posedge clk) begin
    if (rst_) begin
      out_valid <= 1'b0;
      and_q     <= 1'b0;
      dec_q     <= '0;
      flags_q   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        and_q   <= and_d;
        dec_q   <= dec_d;
        flags_q <= flags_d;
      end
    end
  end

  assign {gt, lt, eq} = flags_q;

endmodule

// File: tb/tb_l1_logic_slice.sv
// Self-checking bench for l1_logic_slice: directed steps plus randomized
// traffic against an arithmetic reference model.
module tb_l1_logic_slice;

  localparam int unsigned CMP_W = 4;

  logic             clk = 1'b0;
  logic             rst_ = 1'b1;
  logic             in_valid = 1'b0;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic [CMP_W-1:0] x = '0;
  logic [CMP_W-1:0] y = '0;
  logic             out_valid;
  logic             and_q;
  logic [3:0]       dec_q;
  logic             gt;
  logic             lt;
  logic             eq;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs should show after the last edge.
  int unsigned m_valid = 0;
  int unsigned m_and   = 0;
  int unsigned m_dec   = 0;
  int unsigned m_gt    = 0;
  int unsigned m_lt    = 0;
  int unsigned m_eq    = 0;

  l1_logic_slice #(
    .CMP_W (CMP_W)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .and_q     (and_q),
    .dec_q     (dec_q),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare everything.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic ia, input logic ib,
                      input logic [CMP_W-1:0] ix, input logic [CMP_W-1:0] iy);
    int unsigned xv;
    int unsigned yv;
    @(negedge clk);
    rst_ = r; in_valid = v; a = ia; b = ib; x = ix; y = iy;
    @(posedge clk);
    #1;
    xv = ix;
    yv = iy;
    if (r) begin
      m_valid = 0; m_and = 0; m_dec = 0; m_gt = 0; m_lt = 0; m_eq = 0;
    end else begin
      m_valid = v;
      if (v) begin
        m_and = (ia && ib) ? 1 : 0;
        m_dec = 1 << (2 * int'(ia) + int'(ib));
        m_gt  = (xv > yv) ? 1 : 0;
        m_lt  = (xv < yv) ? 1 : 0;
        m_eq  = (xv == yv) ? 1 : 0;
      end
    end
    check({tag, ".out_valid"}, 32'(out_valid), m_valid);
    check({tag, ".and_q"},     32'(and_q),     m_and);
    check({tag, ".dec_q"},     32'(dec_q),     m_dec);
    check({tag, ".gt"},        32'(gt),        m_gt);
    check({tag, ".lt"},        32'(lt),        m_lt);
    check({tag, ".eq"},        32'(eq),        m_eq);
    if (m_valid == 1)
      check({tag, ".onehot_flags"}, 32'(int'(gt) + int'(lt) + int'(eq)), 32'd1);
  endtask

  initial begin
    // 1: reset held two cycles while a valid-looking sample is presented
    step("rst0", 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd3);
    step("rst1", 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd3);
    check("rst.dec_zero", 32'(dec_q), 32'd0);

    // 2: AND / decoder sweep
    step("sweep00", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
    check("sweep00.dec_lit", 32'(dec_q), 32'h1);
    step("sweep01", 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd1);
    check("sweep01.dec_lit", 32'(dec_q), 32'h2);
    step("sweep10", 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1);
    check("sweep10.dec_lit", 32'(dec_q), 32'h4);
    step("sweep11", 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 4'd1);
    check("sweep11.dec_lit", 32'(dec_q), 32'h8);
    check("sweep11.and_lit", 32'(and_q), 32'h1);

    // 3: directed comparisons, including the range extremes
    step("cmp_9_3",  1'b0, 1'b1, 1'b0, 1'b0, 4'd9,  4'd3);
    check("cmp_9_3.gt_lit", 32'(gt), 32'd1);
    step("cmp_3_9",  1'b0, 1'b1, 1'b0, 1'b0, 4'd3,  4'd9);
    check("cmp_3_9.lt_lit", 32'(lt), 32'd1);
    step("cmp_7_7",  1'b0, 1'b1, 1'b0, 1'b0, 4'd7,  4'd7);
    check("cmp_7_7.eq_lit", 32'(eq), 32'd1);
    step("cmp_15_0", 1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 4'd0);
    check("cmp_15_0.gt_lit", 32'(gt), 32'd1);
    step("cmp_0_15", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd15);
    check("cmp_0_15.lt_lit", 32'(lt), 32'd1);

    // 4: exhaustive operand pairs, back-to-back valid, random a/b
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      pair = 8'(i);
      step("exh", 1'b0, 1'b1, 1'($urandom), 1'($urandom), pair[7:4], pair[3:0]);
    end

    // 5: hold when in_valid drops with inputs toggled
    step("hold_load", 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd8);
    step("hold0",     1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'd1);
    check("hold0.dec_lit", 32'(dec_q), 32'h4);
    check("hold0.lt_lit",  32'(lt),    32'd1);
    step("hold1",     1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd4);
    check("hold1.and_lit", 32'(and_q), 32'd0);

    // 6: reset in the middle of a valid stream; sample in reset cycle dropped
    step("ms_a",   1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 4'd4);
    step("ms_b",   1'b0, 1'b1, 1'b0, 1'b1, 4'd6,  4'd6);
    step("ms_rst", 1'b1, 1'b1, 1'b1, 1'b1, 4'd14, 4'd2);
    check("ms_rst.valid_lit", 32'(out_valid), 32'd0);
    step("ms_post", 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd11);
    check("ms_post.valid_lit", 32'(out_valid), 32'd1);
    check("ms_post.dec_lit",   32'(dec_q),     32'h4);

    // Random traffic with sparse resets and valid gaps
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
